// File: rtl/schem_pkg.sv
// Shared definitions for the AOI schematic sweep driver.
//   state_t    : sweep FSM state encoding
//   VEC_W      : stimulus vector width (4-input AOI)
//   ERR_W      : mismatch counter width (holds 0..16)
//   aoi_expect : golden response of the AOI schematic for a vector
package schem_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned ERR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic aoi_expect(input logic [VEC_W-1:0] v);
    return ~((v[0] & v[1]) | (v[2] & v[3]));
  endfunction

endpackage

// File: rtl/schem_aoi_ref.sv
// Combinational expected-value model of the 4-input AOI schematic.
//   vec     : stimulus vector currently applied to the schematic
//   exp_out : response the schematic should produce for vec
module schem_aoi_ref
  import schem_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp_out
);

  assign exp_out = aoi_expect(vec);

endmodule

// File: rtl/schem_driver.sv
// Exhaustive stimulus driver / checker for a 4-input AOI schematic.
// Each of the 16 vectors is applied, held for SETTLE cycles, then the
// schematic response is compared against the golden model for one cycle.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   start      : request a full sweep (honoured only in IDLE or DONE)
//   drv_in     : stimulus vector driven into the schematic
//   dut_out    : schematic response bit
//   busy       : sweep in progress
//   done       : sweep finished, results stable
//   pass       : valid with done, no mismatches in the sweep
//   err_count  : mismatch count of the current or last sweep (0..16)
//   fail_valid : at least one mismatch recorded in the current or last sweep
//   fail_vec   : first mismatching vector (meaningful with fail_valid)
module schem_driver
  import schem_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] drv_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic             exp_bit;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  schem_aoi_ref u_ref (
    .vec     (drv_in),
    .exp_out (exp_bit)
  );

  assign mismatch = (dut_out != exp_bit);
  // Count including the compare happening this cycle, so pass on entry to
  // DONE already accounts for vector 15.
  assign err_next = err_count + ERR_W'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      drv_in     <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            drv_in     <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) state <= S_SAMPLE;
          else                    cnt   <= cnt + 8'd1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= drv_in;
            end
          end
          if (drv_in == '1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state  <= S_SETTLE;
            drv_in <= drv_in + 4'd1;
            cnt    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schem_driver.sv
// Self-checking bench for schem_driver: three instances (SETTLE = 2, 1, 5),
// each fed by a selectable schematic model (correct AOI, stuck-at-0,
// stuck-at-1). Expected sweep results are queued at start and compared when
// done rises; a per-instance monitor checks vector dwell and stepping.
module tb_schem_driver;

  localparam int SV [3] = '{2, 1, 5};
  localparam int LIMIT = 300;

  typedef struct {
    int lat;
    int err;
    int fv;
    int fvec;
  } exp_t;

  logic       clk;
  logic       rstv   [3];
  logic       startv [3];
  logic [3:0] drv    [3];
  logic       dut_o  [3];
  logic       busyv  [3];
  logic       donev  [3];
  logic       passv  [3];
  logic [4:0] errv   [3];
  logic       fvv    [3];
  logic [3:0] fvecv  [3];
  int         mode   [3];

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  schem_driver #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rstv[0]), .start(startv[0]), .drv_in(drv[0]),
    .dut_out(dut_o[0]), .busy(busyv[0]), .done(donev[0]), .pass(passv[0]),
    .err_count(errv[0]), .fail_valid(fvv[0]), .fail_vec(fvecv[0]));

  schem_driver #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rstv[1]), .start(startv[1]), .drv_in(drv[1]),
    .dut_out(dut_o[1]), .busy(busyv[1]), .done(donev[1]), .pass(passv[1]),
    .err_count(errv[1]), .fail_valid(fvv[1]), .fail_vec(fvecv[1]));

  schem_driver #(.SETTLE(5)) u_dut2 (
    .clk(clk), .rst(rstv[2]), .start(startv[2]), .drv_in(drv[2]),
    .dut_out(dut_o[2]), .busy(busyv[2]), .done(donev[2]), .pass(passv[2]),
    .err_count(errv[2]), .fail_valid(fvv[2]), .fail_vec(fvecv[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schematic under test: 0 = correct AOI, 1 = stuck-at-0, 2 = stuck-at-1
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dut_o[k] = ~((drv[k][0] & drv[k][1]) | (drv[k][2] & drv[k][3]));
      if (mode[k] == 1)      dut_o[k] = 1'b0;
      else if (mode[k] == 2) dut_o[k] = 1'b1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each vector must stay put for SETTLE+1 cycles and advance by one.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    int         run;
    logic [3:0] prev;
    logic       pbusy;
    always @(negedge clk) begin
      if (rstv[g]) begin
        run   = 0;
        pbusy = 1'b0;
      end else begin
        if (busyv[g]) begin
          if (!pbusy) run = 1;
          else if (drv[g] != prev) begin
            check("dwell", run, SV[g] + 1);
            check("step", drv[g], prev + 4'd1);
            run = 1;
          end else run++;
        end else if (pbusy && donev[g]) begin
          check("dwell_last", run, SV[g] + 1);
          check("last_vec", prev, 15);
        end
        pbusy = busyv[g];
        prev  = drv[g];
      end
    end
  end

  task automatic check_reset(input int i);
    check("rst_drv", drv[i], 0);
    check("rst_busy", busyv[i], 0);
    check("rst_done", donev[i], 0);
    check("rst_pass", passv[i], 0);
    check("rst_err", errv[i], 0);
    check("rst_fv", fvv[i], 0);
    check("rst_fvec", fvecv[i], 0);
  endtask

  task automatic wait_done(input int i, input int first, output int cyc);
    cyc = first;
    while (!donev[i] && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!donev[i]) check("done_timeout", cyc, -1);
  endtask

  task automatic score(input int i, input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("latency", cyc, e.lat);
    check("err_count", errv[i], e.err);
    check("pass", passv[i], (e.err == 0) ? 1 : 0);
    check("fail_valid", fvv[i], e.fv);
    if (e.fvec >= 0) check("fail_vec", fvecv[i], e.fvec);
  endtask

  task automatic sweep(input int i, input int m, input int eerr, input int efv,
                       input int efvec, input int repulse);
    int cyc;
    mode[i] = m;
    sb.push_back('{lat: 16 * (SV[i] + 1), err: eerr, fv: efv, fvec: efvec});
    startv[i] = 1'b1;
    @(posedge clk); #1;
    startv[i] = 1'b0;
    check("busy_rise", busyv[i], 1);
    cyc = 0;
    while (!donev[i] && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      startv[i] = (cyc == repulse);
    end
    if (!donev[i]) check("done_timeout", cyc, -1);
    startv[i] = 1'b0;
    score(i, cyc);
    @(posedge clk); #1;
    check("done_hold", donev[i], 1);
    repeat (2) @(posedge clk);
    #1;
    check("no_restart", busyv[i], 0);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 3; k++) begin
      rstv[k]   = 1'b1;
      startv[k] = 1'b0;
      mode[k]   = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset(k);
    for (int k = 0; k < 3; k++) rstv[k] = 1'b0;

    // start raised together with reset release: first edge must honour it
    sweep(0, 0, 0, 0, -1, -1);
    sweep(0, 1, 9, 1, 0, -1);
    sweep(0, 2, 7, 1, 3, -1);

    // DONE with start low holds everything
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", donev[0], 1);
    check("hold_err", errv[0], 7);
    check("hold_fvec", fvecv[0], 3);

    // abort at cycle 20 of a stuck-at-1 sweep, then a clean correct sweep
    mode[0]   = 2;
    startv[0] = 1'b1;
    @(posedge clk); #1;
    startv[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_err_pre", errv[0], 1);
    rstv[0] = 1'b1;
    #1;
    check_reset(0);
    @(posedge clk); #1;
    rstv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_rst", busyv[0], 0);
    sweep(0, 0, 0, 0, -1, -1);

    // start re-pulsed while busy must be ignored
    sweep(0, 1, 9, 1, 0, 10);

    // start held high: back-to-back sweeps, DONE one cycle each
    mode[0] = 0;
    sb.push_back('{lat: 48, err: 0, fv: 0, fvec: -1});
    sb.push_back('{lat: 49, err: 0, fv: 0, fvec: -1});
    startv[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 0, cyc);
    score(0, cyc);
    @(posedge clk); #1;
    check("done_one_cycle", donev[0], 0);
    check("busy_again", busyv[0], 1);
    wait_done(0, 1, cyc);
    startv[0] = 1'b0;
    score(0, cyc);
    @(posedge clk); #1;
    check("held_stop", donev[0], 1);

    // other SETTLE values
    sweep(1, 0, 0, 0, -1, -1);
    sweep(2, 2, 7, 1, 3, -1);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
